enemy_wave_scheduler: RTL

- Sequences a bank of NUM_SLOTS Enemy units through waves: deploys enemies into idle slots at a fixed spacing and issues the periodic move enable.
- Steers each player damage event to the frontmost live enemy and reports the enemy battlefront to the player side.
- Sits between the game top level and the Enemy instances; replaces per-unit hand-driven moveSCEN, damageSCEN and damageIn.

---
 rtl/enemy_wave_scheduler_if.sv | 33 +++
 rtl/enemy_wave_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/enemy_wave_scheduler_if.sv
// Signal bundle between the game top level (master) and the enemy wave scheduler (slave).
interface enemy_wave_scheduler_if #(
    parameter int NUM_SLOTS = 4
);
    logic                   start;
    logic                   pause;
    logic [NUM_SLOTS-1:0]   slotIdle;
    logic [NUM_SLOTS-1:0]   slotAlive;
    logic [9*NUM_SLOTS-1:0] slotPos;
    logic                   playerDmgValid;
    logic [7:0]             playerDmg;
    logic [NUM_SLOTS-1:0]   slotDeploy;
    logic                   moveSCEN;
    logic [NUM_SLOTS-1:0]   damageSCEN;
    logic [7:0]             damageIn;
    logic [8:0]             enemyFront;
    logic                   dmgDropped;
    logic [3:0]             waveNum;
    logic [7:0]             spawnCount;
    logic                   gameDone;

    modport master (
        output start, pause, slotIdle, slotAlive, slotPos, playerDmgValid, playerDmg,
        input  slotDeploy, moveSCEN, damageSCEN, damageIn, enemyFront, dmgDropped,
               waveNum, spawnCount, gameDone
    );

    modport slave (
        input  start, pause, slotIdle, slotAlive, slotPos, playerDmgValid, playerDmg,
        output slotDeploy, moveSCEN, damageSCEN, damageIn, enemyFront, dmgDropped,
               waveNum, spawnCount, gameDone
    );
endinterface

// File: rtl/enemy_wave_scheduler.sv
// Wave sequencer for a bank of Enemy units: spaced deploys, periodic move enable,
// and routing of player damage to the frontmost live enemy.

// One link of the frontmost-enemy chain; strict '<' keeps the lower index on ties.
module ews_front_stage #(
    parameter int NUM_SLOTS = 4,
    parameter int IDX       = 0
) (
    input  logic                 alive,
    input  logic [8:0]           pos,
    input  logic                 found_in,
    input  logic [8:0]           min_in,
    input  logic [NUM_SLOTS-1:0] sel_in,
    output logic                 found_out,
    output logic [8:0]           min_out,
    output logic [NUM_SLOTS-1:0] sel_out
);
    logic take;

    assign take      = alive && (!found_in || (pos < min_in));
    assign found_out = found_in | alive;
    assign min_out   = take ? pos : min_in;

    always_comb begin
        sel_out = sel_in;
        if (take) begin
            sel_out      = '0;
            sel_out[IDX] = 1'b1;
        end
    end
endmodule

module enemy_wave_scheduler #(
    parameter int NUM_SLOTS   = 4,
    parameter int WAVE_SIZE   = 6,
    parameter int NUM_WAVES   = 3,
    parameter int SPAWN_GAP   = 8,
    parameter int MOVE_PERIOD = 4
) (
    input logic                   clk,
    input logic                   reset,
    enemy_wave_scheduler_if.slave bus
);
    localparam int              GW         = $clog2(SPAWN_GAP);
    localparam int              MW         = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [GW-1:0]   GAP_LOAD   = GW'(SPAWN_GAP - 1);
    localparam logic [MW-1:0]   MOVE_LAST  = MW'(MOVE_PERIOD - 1);
    localparam logic [7:0]      SPAWN_LAST = 8'(WAVE_SIZE - 1);
    localparam logic [3:0]      WAVE_LAST  = 4'(NUM_WAVES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN_WAIT,
        S_SPAWN,
        S_WAVE_CLEAR,
        S_DONE
    } state_t;

    state_t               state, state_n;
    logic [GW-1:0]        gap_q, gap_n;
    logic [MW-1:0]        mcnt_q, mcnt_n;
    logic [3:0]           wave_q, wave_n;
    logic [7:0]           spawn_q, spawn_n;
    logic                 active, run;
    logic [NUM_SLOTS-1:0] idle_pick;

    assign active = (state == S_SPAWN_WAIT) || (state == S_SPAWN) || (state == S_WAVE_CLEAR);
    assign run    = active && !bus.pause;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            gap_q   <= '0;
            mcnt_q  <= '0;
            wave_q  <= '0;
            spawn_q <= '0;
        end else begin
            state   <= state_n;
            gap_q   <= gap_n;
            mcnt_q  <= mcnt_n;
            wave_q  <= wave_n;
            spawn_q <= spawn_n;
        end
    end

    always_comb begin
        state_n = state;
        gap_n   = gap_q;
        mcnt_n  = mcnt_q;
        wave_n  = wave_q;
        spawn_n = spawn_q;
        if (run) mcnt_n = (mcnt_q == MOVE_LAST) ? '0 : mcnt_q + 1'b1;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    wave_n  = '0;
                    spawn_n = '0;
                    gap_n   = GAP_LOAD;
                    mcnt_n  = '0;
                    state_n = S_SPAWN_WAIT;
                end
            end
            S_SPAWN_WAIT: begin
                if (!bus.pause) begin
                    if (gap_q == '0) state_n = S_SPAWN;
                    else             gap_n   = gap_q - 1'b1;
                end
            end
            S_SPAWN: begin
                // With no idle slot we simply sit here until one frees up.
                if (!bus.pause && |bus.slotIdle) begin
                    spawn_n = spawn_q + 1'b1;
                    gap_n   = GAP_LOAD;
                    state_n = (spawn_q == SPAWN_LAST) ? S_WAVE_CLEAR : S_SPAWN_WAIT;
                end
            end
            S_WAVE_CLEAR: begin
                if (!bus.pause && &bus.slotIdle) begin
                    if (wave_q == WAVE_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        wave_n  = wave_q + 1'b1;
                        spawn_n = '0;
                        gap_n   = GAP_LOAD;
                        state_n = S_SPAWN_WAIT;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        idle_pick = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (bus.slotIdle[i]) begin
                idle_pick    = '0;
                idle_pick[i] = 1'b1;
            end
        end
    end

    assign bus.slotDeploy = (state == S_SPAWN && !bus.pause) ? idle_pick : '0;
    assign bus.moveSCEN   = run && (mcnt_q == MOVE_LAST);
    assign bus.waveNum    = wave_q;
    assign bus.spawnCount = spawn_q;
    assign bus.gameDone   = (state == S_DONE);

    // Frontmost alive enemy: chain of compare stages, slot 0 first.
    logic [NUM_SLOTS:0]                found_c;
    logic [NUM_SLOTS:0][8:0]           min_c;
    logic [NUM_SLOTS:0][NUM_SLOTS-1:0] sel_c;

    assign found_c[0] = 1'b0;
    assign min_c[0]   = 9'h1FF;
    assign sel_c[0]   = '0;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_front
        ews_front_stage #(
            .NUM_SLOTS (NUM_SLOTS),
            .IDX       (i)
        ) u_stage (
            .alive     (bus.slotAlive[i]),
            .pos       (bus.slotPos[9*i +: 9]),
            .found_in  (found_c[i]),
            .min_in    (min_c[i]),
            .sel_in    (sel_c[i]),
            .found_out (found_c[i+1]),
            .min_out   (min_c[i+1]),
            .sel_out   (sel_c[i+1])
        );
    end

    logic [NUM_SLOTS-1:0] dmg_sel_q;
    logic [7:0]           dmg_amt_q;
    logic                 dropped_q;
    logic [8:0]           front_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dmg_sel_q <= '0;
            dmg_amt_q <= '0;
            dropped_q <= 1'b0;
            front_q   <= 9'h1FF;
        end else begin
            front_q   <= min_c[NUM_SLOTS];
            dmg_sel_q <= bus.playerDmgValid ? sel_c[NUM_SLOTS] : '0;
            dmg_amt_q <= (bus.playerDmgValid && found_c[NUM_SLOTS]) ? bus.playerDmg : 8'd0;
            dropped_q <= bus.playerDmgValid && !found_c[NUM_SLOTS];
        end
    end

    assign bus.damageSCEN = dmg_sel_q;
    assign bus.damageIn   = dmg_amt_q;
    assign bus.dmgDropped = dropped_q;
    assign bus.enemyFront = front_q;
endmodule
